// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM states,
// owner encoding and the request bundle presented to datamemory.
package dmem_arb_pkg;

  localparam int ARB_AW = 9;
  localparam int ARB_DW = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_RDW = 2'd1,
    DBG_RDW = 2'd2
  } arb_state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DBG  = 2'b10;

  // Field widths track ARB_AW/ARB_DW, which are the arbiter's default widths.
  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ARB_AW-1:0] addr;
    logic [ARB_DW-1:0] wdata;
    logic [2:0]        func3;
  } mem_req_t;

endpackage

// File: rtl/arb_prio_sel.sv
// Combinational winner select for the data-memory arbiter: lock first,
// then the starvation override, then fixed cpu priority, then dbg.
module arb_prio_sel (
  input  logic cpu_req_i,
  input  logic dbg_req_i,
  input  logic lock_held_i,
  input  logic starve_hit_i,
  output logic cpu_win_o,
  output logic dbg_win_o
);

  always_comb begin
    cpu_win_o = 1'b0;
    dbg_win_o = 1'b0;
    // A held lock shuts the cpu out even when dbg has nothing to issue.
    if (lock_held_i) begin
      dbg_win_o = dbg_req_i;
    end else if (starve_hit_i && dbg_req_i) begin
      dbg_win_o = 1'b1;
    end else if (cpu_req_i) begin
      cpu_win_o = 1'b1;
    end else if (dbg_req_i) begin
      dbg_win_o = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the MEM stage and a debug/loader port.
// Loads occupy one extra cycle; read data is passed straight through to the owner.
//   state   | meaning
//   IDLE    | arbitrate and issue to memory this cycle
//   CPU_RDW | cpu load data returning on mem_rdata
//   DBG_RDW | dbg load data returning on mem_rdata
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DM_ADDRESS = ARB_AW,
  parameter int DATA_W     = ARB_DW,
  parameter int STARVE_LIM = 4,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [DM_ADDRESS-1:0] cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [2:0]            cpu_func3,
  output logic                  cpu_stall,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_rvalid,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [DM_ADDRESS-1:0] dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  input  logic [2:0]            dbg_func3,
  input  logic                  dbg_lock,
  output logic                  dbg_gnt,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic                  dbg_rvalid,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_func3,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [1:0]            owner
);

  arb_state_t        state_q;
  logic [CNT_W-1:0]  starve_cnt_q;
  logic              lock_held_q;
  logic [1:0]        owner_q;

  logic     cpu_req;
  logic     starve_hit;
  logic     sel_cpu;
  logic     sel_dbg;
  logic     issue_en;
  logic     cpu_go;
  logic     dbg_go;
  mem_req_t mem_req;

  assign cpu_req    = cpu_rd | cpu_wr;
  assign starve_hit = (starve_cnt_q >= CNT_W'(STARVE_LIM));

  arb_prio_sel u_prio_sel (
    .cpu_req_i    (cpu_req),
    .dbg_req_i    (dbg_req),
    .lock_held_i  (lock_held_q),
    .starve_hit_i (starve_hit),
    .cpu_win_o    (sel_cpu),
    .dbg_win_o    (sel_dbg)
  );

  // Gating with reset keeps memory strobes and grants quiet while reset is held.
  assign issue_en = (state_q == IDLE) && reset;
  assign cpu_go   = issue_en & sel_cpu;
  assign dbg_go   = issue_en & sel_dbg;

  always_comb begin
    mem_req = '0;
    if (cpu_go) begin
      mem_req.rd    = cpu_rd & ~cpu_wr;
      mem_req.wr    = cpu_wr;
      mem_req.addr  = cpu_addr;
      mem_req.wdata = cpu_wdata;
      mem_req.func3 = cpu_func3;
    end else if (dbg_go) begin
      mem_req.rd    = ~dbg_we;
      mem_req.wr    = dbg_we;
      mem_req.addr  = dbg_addr;
      mem_req.wdata = dbg_wdata;
      mem_req.func3 = dbg_func3;
    end
  end

  assign mem_rd    = mem_req.rd;
  assign mem_wr    = mem_req.wr;
  assign mem_addr  = mem_req.addr;
  assign mem_wdata = mem_req.wdata;
  assign mem_func3 = mem_req.func3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      lock_held_q  <= 1'b0;
      owner_q      <= OWN_NONE;
    end else begin
      // Dropping dbg_lock releases ownership on any cycle, granted or not.
      lock_held_q <= dbg_lock & (lock_held_q | dbg_go);
      case (state_q)
        IDLE: begin
          if (cpu_go) begin
            owner_q <= OWN_CPU;
          end else if (dbg_go) begin
            owner_q <= OWN_DBG;
          end else begin
            owner_q <= OWN_NONE;
          end

          if (dbg_go) begin
            starve_cnt_q <= '0;
          end else if (dbg_req && (starve_cnt_q != '1)) begin
            starve_cnt_q <= starve_cnt_q + CNT_W'(1);
          end

          if (cpu_go && cpu_rd && !cpu_wr) begin
            state_q <= CPU_RDW;
          end else if (dbg_go && !dbg_we) begin
            state_q <= DBG_RDW;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign owner      = owner_q;
  assign dbg_gnt    = dbg_go;
  assign cpu_rvalid = (state_q == CPU_RDW);
  assign dbg_rvalid = (state_q == DBG_RDW);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

  // A cpu load keeps stalling through its grant cycle and releases in the data cycle.
  assign cpu_stall = cpu_req & ~((cpu_go & cpu_wr) | (state_q == CPU_RDW));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by
// protocol-respecting random traffic, all compared against a cycle-level model.
module tb_dmem_arbiter;

  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int SLIM  = 4;
  localparam int CW    = 4;
  localparam int CMAX  = 15;

  logic          clk;
  logic          reset;
  logic          cpu_rd, cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [2:0]    cpu_func3;
  logic          cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic          dbg_req, dbg_we, dbg_lock;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic [2:0]    dbg_func3;
  logic          dbg_gnt;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_rvalid;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_func3;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    owner;

  dmem_arbiter #(
    .DM_ADDRESS (AW),
    .DATA_W     (DW),
    .STARVE_LIM (SLIM),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_func3  (cpu_func3),
    .cpu_stall  (cpu_stall),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_func3  (dbg_func3),
    .dbg_lock   (dbg_lock),
    .dbg_gnt    (dbg_gnt),
    .dbg_rdata  (dbg_rdata),
    .dbg_rvalid (dbg_rvalid),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_func3  (mem_func3),
    .mem_rdata  (mem_rdata),
    .owner      (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending read owner (0 none, 1 cpu, 2 dbg), denied count, lock, last owner.
  int   m_wait, m_starve, m_own, m_win;
  bit   m_lock;
  logic e_stall, e_gnt;

  task automatic model_reset();
    m_wait = 0; m_starve = 0; m_own = 0; m_lock = 0; m_win = 0;
    e_stall = 0; e_gnt = 0;
  endtask

  task automatic eval_check();
    logic          creq;
    logic          x_rd, x_wr, x_crv, x_drv;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_wdata, x_crd, x_drd;
    logic [2:0]    x_f3;
    #2;
    creq = cpu_rd | cpu_wr;
    x_rd = 0; x_wr = 0; x_addr = '0; x_wdata = '0; x_f3 = '0;
    x_crv = 0; x_drv = 0; x_crd = '0; x_drd = '0;
    e_gnt = 0;
    m_win = 0;
    if (m_wait == 0) begin
      if (m_lock) begin
        if (dbg_req) m_win = 2;
      end else if (m_starve >= SLIM && dbg_req) m_win = 2;
      else if (creq) m_win = 1;
      else if (dbg_req) m_win = 2;
      if (m_win == 1) begin
        x_wr = cpu_wr; x_rd = cpu_rd & ~cpu_wr;
        x_addr = cpu_addr; x_wdata = cpu_wdata; x_f3 = cpu_func3;
      end else if (m_win == 2) begin
        e_gnt = 1;
        x_wr = dbg_we; x_rd = ~dbg_we;
        x_addr = dbg_addr; x_wdata = dbg_wdata; x_f3 = dbg_func3;
      end
      e_stall = creq && !(m_win == 1 && cpu_wr);
    end else begin
      e_stall = creq && (m_wait != 1);
      if (m_wait == 1) begin x_crv = 1; x_crd = mem_rdata; end
      else begin x_drv = 1; x_drd = mem_rdata; end
    end
    check("cpu_stall", cpu_stall, e_stall);
    check("mem_rd", mem_rd, x_rd);
    check("mem_wr", mem_wr, x_wr);
    check("mem_addr", mem_addr, x_addr);
    check("mem_wdata", mem_wdata, x_wdata);
    check("mem_func3", mem_func3, x_f3);
    check("dbg_gnt", dbg_gnt, e_gnt);
    check("cpu_rvalid", cpu_rvalid, x_crv);
    check("cpu_rdata", cpu_rdata, x_crd);
    check("dbg_rvalid", dbg_rvalid, x_drv);
    check("dbg_rdata", dbg_rdata, x_drd);
    check("owner", owner, m_own);
    // advance to the state after the coming rising edge
    if (m_wait == 0) begin
      m_own = m_win;
      if (m_win == 2) m_starve = 0;
      else if (dbg_req && m_starve < CMAX) m_starve++;
      if (m_win == 1 && cpu_rd && !cpu_wr) m_wait = 1;
      else if (m_win == 2 && !dbg_we) m_wait = 2;
      else m_wait = 0;
    end else begin
      m_wait = 0;
    end
    m_lock = dbg_lock && (m_lock || m_win == 2);
  endtask

  task automatic next_cycle();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic drive_cpu(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d; cpu_func3 = 3'd2;
  endtask

  task automatic drive_dbg(input logic req, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic lk);
    dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_func3 = 3'd2; dbg_lock = lk;
  endtask

  task automatic check_reset_outputs();
    #2;
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_dbg_gnt", dbg_gnt, 0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_dbg_rvalid", dbg_rvalid, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_dbg_rdata", dbg_rdata, 0);
    check("rst_owner", owner, 0);
    check("rst_cpu_stall", cpu_stall, 0);
    model_reset();
  endtask

  initial begin
    int gnt_cycle, cpu_cnt, gnt_cnt;
    reset = 1'b0;
    drive_cpu(0, 0, '0, '0);
    drive_dbg(0, 0, '0, '0, 0);
    mem_rdata = '0;
    check_reset_outputs();

    // cpu store alone
    next_cycle(); drive_cpu(0, 1, 9'h010, 32'hDEADBEEF); eval_check();
    check("store_mem_wr", mem_wr, 1);
    check("store_stall", cpu_stall, 0);
    next_cycle(); drive_cpu(0, 0, '0, '0); eval_check();
    check("store_owner", owner, 2'b01);

    // cpu load: stall in grant cycle, data the next
    next_cycle(); drive_cpu(1, 0, 9'h010, '0); eval_check();
    check("load_stall_n", cpu_stall, 1);
    check("load_mem_rd_n", mem_rd, 1);
    next_cycle(); mem_rdata = 32'hDEADBEEF; eval_check();
    check("load_stall_n1", cpu_stall, 0);
    check("load_rvalid", cpu_rvalid, 1);
    check("load_rdata", cpu_rdata, 32'hDEADBEEF);
    check("load_no_reissue", mem_rd, 0);
    next_cycle(); drive_cpu(0, 0, '0, '0); mem_rdata = '0; eval_check();

    // starvation: cpu store vs dbg write held
    gnt_cycle = 0; cpu_cnt = 0;
    for (int i = 0; i < 8 && gnt_cycle == 0; i++) begin
      next_cycle(); drive_cpu(0, 1, 9'h040, i); drive_dbg(1, 1, 9'h080, 32'h5A5A0000 + i, 0);
      eval_check();
      if (dbg_gnt) begin
        gnt_cycle = i + 1;
        check("starve_gnt_stall", cpu_stall, 1);
      end else if (mem_wr) cpu_cnt++;
    end
    check("starve_gnt_cycle", gnt_cycle, 5);
    check("starve_cpu_wins", cpu_cnt, 4);
    next_cycle(); drive_dbg(0, 0, '0, '0, 0); eval_check();
    next_cycle(); drive_dbg(1, 1, 9'h084, 32'h1, 0); eval_check();
    check("starve_cleared", dbg_gnt, 0);

    // locked dbg burst while a cpu load waits
    gnt_cnt = 0;
    next_cycle(); drive_cpu(0, 0, '0, '0); drive_dbg(1, 1, 9'h020, 32'hA0, 1); eval_check();
    gnt_cnt += dbg_gnt;
    next_cycle(); drive_cpu(1, 0, 9'h100, '0); drive_dbg(1, 1, 9'h024, 32'hA4, 1); eval_check();
    gnt_cnt += dbg_gnt; check("lock_stall_b", cpu_stall, 1);
    next_cycle(); drive_dbg(1, 1, 9'h028, 32'hA8, 1); eval_check();
    gnt_cnt += dbg_gnt; check("lock_stall_c", cpu_stall, 1);
    check("lock_gnt_pulses", gnt_cnt, 3);
    next_cycle(); drive_dbg(0, 0, '0, '0, 0); eval_check();
    check("lock_stall_d", cpu_stall, 1);
    check("lock_no_cpu_d", mem_rd, 0);
    next_cycle(); eval_check();
    check("lock_cpu_granted", mem_rd, 1);
    next_cycle(); mem_rdata = 32'h12345678; eval_check();
    check("lock_cpu_rdata", cpu_rdata, 32'h12345678);

    // rd and wr together behave as a store
    next_cycle(); drive_cpu(1, 1, 9'h030, 32'hCAFE); mem_rdata = '0; eval_check();
    check("rdwr_mem_wr", mem_wr, 1);
    check("rdwr_mem_rd", mem_rd, 0);
    next_cycle(); drive_cpu(0, 0, '0, '0); eval_check();
    check("rdwr_no_rvalid", cpu_rvalid, 0);

    // reset during a dbg read wait
    next_cycle(); drive_dbg(1, 0, 9'h044, '0, 0); eval_check();
    check("rstload_mem_rd", mem_rd, 1);
    @(negedge clk);
    reset = 1'b0; drive_dbg(0, 0, '0, '0, 0); mem_rdata = 32'hFFFF0000;
    check_reset_outputs();
    next_cycle(); eval_check();
    check("rstload_no_rvalid", dbg_rvalid, 0);
    next_cycle(); drive_cpu(0, 1, 9'h050, 32'h77); eval_check();
    check("post_rst_store", mem_wr, 1);

    // random traffic obeying the hold rules
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      if (!e_stall) begin
        cpu_rd = ($urandom % 2) == 0;
        cpu_wr = ($urandom % 3) == 0;
        cpu_addr = AW'($urandom); cpu_wdata = $urandom; cpu_func3 = 3'($urandom);
      end
      if (!(dbg_req && !e_gnt)) begin
        dbg_req = ($urandom % 5) < 2;
        dbg_we = ($urandom % 2) == 0;
        dbg_addr = AW'($urandom); dbg_wdata = $urandom; dbg_func3 = 3'($urandom);
      end
      dbg_lock = ($urandom % 3) == 0;
      mem_rdata = $urandom;
      eval_check();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
